// File: rtl/trace_capture_unit.sv
// ----------------------------------------------------------------------------
// trace_capture_unit
//
// Purpose:
//   Consumer end of the CPU wrapper's instruction-trace interface. Each cycle
//   with trace_valid high is one commit. The unit stores its {pc, inst} pair in
//   a circular buffer and drains the buffer over a valid/ready word stream.
//   Each entry goes out as two beats: pc first, then inst, with out_last high
//   on the inst beat. The unit also keeps a retire counter, a saturating
//   dropped-entry counter and the pc of the most recent commit.
//
// Parameters:
//   DEPTH_LOG2  log2 of the buffer depth in entries (default 4, 16 entries)
//   RESET_PC    value reported on last_pc after reset
//
// Ports:
//   clk_in       system clock, rising edge
//   reset_n      synchronous active-low reset
//   trace_valid  commit strobe; trace_pc / trace_inst qualified by it
//   out_valid    out_data holds a valid beat
//   out_ready    reader accepts the beat when out_valid and out_ready are high
//   out_data     beat payload (pc beat, then inst beat)
//   out_last     high on the inst beat of an entry
//   count        entries currently buffered (0 .. 2**DEPTH_LOG2)
//   retired      commits seen since reset, wraps at 2**32
//   dropped      commits lost to a full buffer, saturates at 16'hFFFF
//   last_pc      pc of the most recent commit
//
// Optional feature (macro TRACE_TRIGGER_EN):
//   Adds trig_addr (in) and trig_hit (out). A commit whose pc equals trig_addr
//   is captured normally and sets trig_hit, which is sticky until reset. While
//   trig_hit is high, later commits are neither stored nor counted as dropped.
//   retired and last_pc keep updating. Without the macro, capture is never
//   frozen.
// ----------------------------------------------------------------------------
module trace_capture_unit #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [31:0] RESET_PC   = 32'h00400000
) (
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic                trace_valid,
    input  logic [31:0]         trace_pc,
    input  logic [31:0]         trace_inst,
`ifdef TRACE_TRIGGER_EN
    input  logic [31:0]         trig_addr,
    output logic                trig_hit,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_data,
    output logic                out_last,
    output logic [DEPTH_LOG2:0] count,
    output logic [31:0]         retired,
    output logic [15:0]         dropped,
    output logic [31:0]         last_pc
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    // Read FSM encoding.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND_PC   = 2'd1;
    localparam logic [1:0] ST_SEND_INST = 2'd2;

    // Entry storage, split into pc and inst halves.
    logic [31:0] mem_pc   [DEPTH];
    logic [31:0] mem_inst [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [1:0]            state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [31:0]           retired_q, retired_d;
    logic [15:0]           dropped_q, dropped_d;
    logic [31:0]           last_pc_q, last_pc_d;

    logic                  frozen;
    logic                  full;
    logic                  capture_en;
    logic                  mem_we;
    logic                  pop;
    logic [DEPTH_LOG2-1:0] rd_ptr_inc;

`ifdef TRACE_TRIGGER_EN
    logic trig_hit_q, trig_hit_d;

    // The matching commit sees the old (clear) flag, so it is still captured.
    assign frozen   = trig_hit_q;
    assign trig_hit = trig_hit_q;

    always_comb begin
        trig_hit_d = trig_hit_q | (trace_valid & (trace_pc == trig_addr));
    end
`else
    assign frozen = 1'b0;
`endif

    // Fullness is taken from the registered count, before any pop in this
    // cycle. A pop that completes on the same edge therefore cannot make room
    // for a write.
    assign full       = (count_q == FULL_COUNT);
    assign capture_en = trace_valid & ~frozen;
    assign mem_we     = capture_en & ~full;
    assign rd_ptr_inc = rd_ptr_q + PTR_ONE;

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a variable
        // unassigned, which would otherwise infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        retired_d   = retired_q;
        dropped_d   = dropped_q;
        last_pc_d   = last_pc_q;
        pop         = 1'b0;

        // retired and last_pc track every commit, whether it is stored or not.
        if (trace_valid) begin
            retired_d = retired_q + 32'd1;
            last_pc_d = trace_pc;
        end

        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (capture_en && full && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end

        // While out_valid is high, beat registers change only on a handshake,
        // so the stream stays stable under backpressure.
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    out_data_d  = mem_pc[rd_ptr_q];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    state_d     = ST_SEND_PC;
                end
            end
            ST_SEND_PC: begin
                if (out_ready) begin
                    out_data_d = mem_inst[rd_ptr_q];
                    out_last_d = 1'b1;
                    state_d    = ST_SEND_INST;
                end
            end
            ST_SEND_INST: begin
                if (out_ready) begin
                    pop      = 1'b1;
                    rd_ptr_d = rd_ptr_inc;
                    // Chain straight into the next entry only if it was
                    // already in memory before this edge. An entry being
                    // written this cycle is picked up from IDLE next cycle.
                    if (count_q > CNT_ONE) begin
                        out_data_d = mem_pc[rd_ptr_inc];
                        out_last_d = 1'b0;
                        state_d    = ST_SEND_PC;
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        case ({mem_we, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments, so every flop samples pre-edge
        // values regardless of statement order.
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_last_q  <= 1'b0;
            retired_q   <= 32'd0;
            dropped_q   <= 16'd0;
            last_pc_q   <= RESET_PC;
`ifdef TRACE_TRIGGER_EN
            trig_hit_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            retired_q   <= retired_d;
            dropped_q   <= dropped_d;
            last_pc_q   <= last_pc_d;
`ifdef TRACE_TRIGGER_EN
            trig_hit_q  <= trig_hit_d;
`endif
        end
    end

    // NOTE: the entry memory has no reset. A slot is read only after it has
    // been written, because count gates every read, so clearing it would cost
    // logic and buy nothing.
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem_pc[wr_ptr_q]   <= trace_pc;
            mem_inst[wr_ptr_q] <= trace_inst;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign count     = count_q;
    assign retired   = retired_q;
    assign dropped   = dropped_q;
    assign last_pc   = last_pc_q;

endmodule

// File: tb/tb_trace_capture_unit.sv
// ----------------------------------------------------------------------------
// tb_trace_capture_unit
//
// Self-checking bench for trace_capture_unit. It runs:
//   - a vector table covering reset, a single commit and a two-entry drain
//   - hand-written sequences for backpressure, mid-transfer reset, overflow
//     (including a commit on a full buffer during a pop), a simultaneous
//     commit and pop, and dropped-counter saturation
//   - randomized traffic checked against a word-queue reference model
//   - the trigger sequence when TRACE_TRIGGER_EN is defined
// ----------------------------------------------------------------------------
module tb_trace_capture_unit;

    localparam int          DEPTH_LOG2 = 4;
    localparam int          DEPTH      = 16;
    localparam logic [31:0] RESET_PC   = 32'h00400000;

    logic                clk_in = 1'b0;
    logic                reset_n;
    logic                trace_valid;
    logic [31:0]         trace_pc;
    logic [31:0]         trace_inst;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_data;
    logic                out_last;
    logic [DEPTH_LOG2:0] count;
    logic [31:0]         retired;
    logic [15:0]         dropped;
    logic [31:0]         last_pc;
`ifdef TRACE_TRIGGER_EN
    logic [31:0]         trig_addr;
    logic                trig_hit;
`endif

    trace_capture_unit #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_inst  (trace_inst),
`ifdef TRACE_TRIGGER_EN
        .trig_addr   (trig_addr),
        .trig_hit    (trig_hit),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .count       (count),
        .retired     (retired),
        .dropped     (dropped),
        .last_pc     (last_pc)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        trace_valid = 1'b0;
        trace_pc    = 32'd0;
        trace_inst  = 32'd0;
        out_ready   = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] inst);
        trace_valid = 1'b1;
        trace_pc    = pc;
        trace_inst  = inst;
        step();
        trace_valid = 1'b0;
    endtask

    // Drain n_beats with out_ready high and compare each one against the
    // expected entries, which are addressed by index into pcs/insts.
    task automatic drain_expect(input string tag, input logic [31:0] pcs[$],
                                input logic [31:0] insts[$]);
        int budget;
        out_ready = 1'b1;
        for (int b = 0; b < 2 * pcs.size(); b++) begin
            budget = 0;
            while (!out_valid && budget < 20) begin
                step();
                budget++;
            end
            check($sformatf("%s.valid%0d", tag, b), out_valid, 1'b1);
            check($sformatf("%s.data%0d", tag, b), out_data,
                  (b % 2 == 0) ? pcs[b/2] : insts[b/2]);
            check($sformatf("%s.last%0d", tag, b), out_last, (b % 2 == 1));
            step();
        end
        check($sformatf("%s.count_end", tag), count, 0);
    endtask

    typedef struct {
        logic        rst_n;
        logic        tv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rdy;
        logic        ov;
        logic        chk_data;
        logic [31:0] data;
        logic        last;
        logic [4:0]  cnt;
        logic [31:0] ret;
        logic [15:0] drp;
        logic [31:0] lpc;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pcs[$];
        logic [31:0] insts[$];
        logic [31:0] exp_words[$];
        int          words_popped;
        int          starve;
        int          entries_pre;
        int          rdy_pct;
        logic        hs;
        logic        pv;
        logic        pl;
        logic [31:0] pd;
        logic [31:0] m_ret;
        logic [15:0] m_drop;
        logic [31:0] m_lpc;

        reset_n     = 1'b0;
        trace_valid = 1'b0;
        trace_pc    = 32'd0;
        trace_inst  = 32'd0;
        out_ready   = 1'b0;
`ifdef TRACE_TRIGGER_EN
        trig_addr   = 32'd0;
`endif

        // rst tv pc inst rdy | ov chk data last cnt ret drp lpc
        vecs[0]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1,
                     1'b0, 1'b1, 32'h0, 1'b0, 5'd0, 32'd0, 16'd0, 32'h00400000};
        vecs[1]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1,
                     1'b0, 1'b1, 32'h0, 1'b0, 5'd0, 32'd0, 16'd0, 32'h00400000};
        vecs[2]  = '{1'b1, 1'b1, 32'h00400000, 32'h3C010040, 1'b1,
                     1'b0, 1'b0, 32'h0, 1'b0, 5'd1, 32'd1, 16'd0, 32'h00400000};
        vecs[3]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1,
                     1'b1, 1'b1, 32'h00400000, 1'b0, 5'd1, 32'd1, 16'd0, 32'h00400000};
        vecs[4]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1,
                     1'b1, 1'b1, 32'h3C010040, 1'b1, 5'd1, 32'd1, 16'd0, 32'h00400000};
        vecs[5]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'd1, 16'd0, 32'h00400000};
        vecs[6]  = '{1'b1, 1'b1, 32'h00400004, 32'h11111111, 1'b0,
                     1'b0, 1'b0, 32'h0, 1'b0, 5'd1, 32'd2, 16'd0, 32'h00400004};
        vecs[7]  = '{1'b1, 1'b1, 32'h00400008, 32'h22222222, 1'b0,
                     1'b1, 1'b1, 32'h00400004, 1'b0, 5'd2, 32'd3, 16'd0, 32'h00400008};
        vecs[8]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b0,
                     1'b1, 1'b1, 32'h00400004, 1'b0, 5'd2, 32'd3, 16'd0, 32'h00400008};
        vecs[9]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1,
                     1'b1, 1'b1, 32'h11111111, 1'b1, 5'd2, 32'd3, 16'd0, 32'h00400008};
        vecs[10] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1,
                     1'b1, 1'b1, 32'h00400008, 1'b0, 5'd1, 32'd3, 16'd0, 32'h00400008};
        vecs[11] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1,
                     1'b1, 1'b1, 32'h22222222, 1'b1, 5'd1, 32'd3, 16'd0, 32'h00400008};
        vecs[12] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'd3, 16'd0, 32'h00400008};

        // ---------------- table: reset, single commit, two-entry drain -------
        for (int i = 0; i < 13; i++) begin
            reset_n     = vecs[i].rst_n;
            trace_valid = vecs[i].tv;
            trace_pc    = vecs[i].pc;
            trace_inst  = vecs[i].inst;
            out_ready   = vecs[i].rdy;
            step();
            check($sformatf("vec%0d.out_valid", i), out_valid, vecs[i].ov);
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d.out_data", i), out_data, vecs[i].data);
                check($sformatf("vec%0d.out_last", i), out_last, vecs[i].last);
            end
            check($sformatf("vec%0d.count", i), count, vecs[i].cnt);
            check($sformatf("vec%0d.retired", i), retired, vecs[i].ret);
            check($sformatf("vec%0d.dropped", i), dropped, vecs[i].drp);
            check($sformatf("vec%0d.last_pc", i), last_pc, vecs[i].lpc);
        end
        trace_valid = 1'b0;

        // ---------------- backpressure: 3 entries held, then 6 beats ---------
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) commit(32'h00500000 + 32'(4 * i), 32'hB0000000 + 32'(i));
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp.hold_valid", out_valid, 1'b1);
            check("bp.hold_data", out_data, 32'h00500000);
            check("bp.hold_count", count, 3);
        end
        out_ready = 1'b1;
        for (int b = 0; b < 6; b++) begin
            check($sformatf("bp.valid%0d", b), out_valid, 1'b1);
            check($sformatf("bp.data%0d", b), out_data,
                  (b % 2 == 0) ? 32'h00500000 + 32'(4 * (b / 2)) : 32'hB0000000 + 32'(b / 2));
            check($sformatf("bp.last%0d", b), out_last, (b % 2 == 1));
            step();
        end
        check("bp.done_valid", out_valid, 1'b0);
        check("bp.done_count", count, 0);

        // ---------------- reset in the middle of a transfer ------------------
        out_ready = 1'b0;
        commit(32'h00600000, 32'hC0000000);
        commit(32'h00600004, 32'hC0000001);
        check("midrst.pre_valid", out_valid, 1'b1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("midrst.valid", out_valid, 1'b0);
        check("midrst.count", count, 0);
        check("midrst.retired", retired, 0);
        check("midrst.last_pc", last_pc, RESET_PC);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst.stays_empty", out_valid, 1'b0);
        end

        // ---------------- overflow, then a commit on a full buffer mid-pop ---
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) commit(32'h00401000 + 32'(4 * i), 32'hA0000000 + 32'(i));
        check("ovf.count", count, DEPTH);
        check("ovf.dropped", dropped, 4);
        check("ovf.retired", retired, 20);
        check("ovf.last_pc", last_pc, 32'h00401000 + 32'(4 * 19));
        check("ovf.first_pc", out_data, 32'h00401000);
        out_ready = 1'b1;
        step();
        check("ovf.first_inst", out_data, 32'hA0000000);
        trace_valid = 1'b1;
        trace_pc    = 32'hDEAD0000;
        trace_inst  = 32'hDEAD0001;
        step();
        trace_valid = 1'b0;
        check("ovf.pop_full_dropped", dropped, 5);
        check("ovf.pop_full_count", count, DEPTH - 1);
        check("ovf.pop_full_retired", retired, 21);
        check("ovf.no_bubble", out_valid, 1'b1);
        pcs.delete();
        insts.delete();
        for (int i = 1; i < 16; i++) begin
            pcs.push_back(32'h00401000 + 32'(4 * i));
            insts.push_back(32'hA0000000 + 32'(i));
        end
        drain_expect("ovf.drain", pcs, insts);

        // ---------------- simultaneous commit and pop at count 5 -------------
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) commit(32'h00700000 + 32'(4 * i), 32'hE0000000 + 32'(i));
        out_ready = 1'b1;
        step();
        check("sim.inst_beat", out_last, 1'b1);
        check("sim.count_pre", count, 5);
        trace_valid = 1'b1;
        trace_pc    = 32'h00700014;
        trace_inst  = 32'hE0000005;
        step();
        trace_valid = 1'b0;
        out_ready   = 1'b0;
        check("sim.count", count, 5);
        check("sim.next_pc", out_data, 32'h00700004);
        pcs.delete();
        insts.delete();
        for (int i = 1; i < 6; i++) begin
            pcs.push_back(32'h00700000 + 32'(4 * i));
            insts.push_back(32'hE0000000 + 32'(i));
        end
        drain_expect("sim.drain", pcs, insts);

        // ---------------- dropped counter saturation -------------------------
        do_reset();
        out_ready   = 1'b0;
        trace_valid = 1'b1;
        trace_inst  = 32'h0;
        for (int i = 0; i < DEPTH + 65540; i++) begin
            trace_pc = 32'h00800000 + 32'(i);
            step();
        end
        trace_valid = 1'b0;
        check("sat.dropped", dropped, 16'hFFFF);
        check("sat.count", count, DEPTH);
        check("sat.retired", retired, DEPTH + 65540);

        // ---------------- randomized traffic vs word-queue model -------------
        do_reset();
        exp_words.delete();
        words_popped = 0;
        starve       = 0;
        m_ret        = 32'd0;
        m_drop       = 16'd0;
        m_lpc        = RESET_PC;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy_pct     = ((cyc / 500) % 2 == 0) ? 25 : 80;
            trace_valid = ($urandom_range(99) < 45);
            trace_pc    = $urandom | 32'h1;
            trace_inst  = $urandom;
            out_ready   = ($urandom_range(99) < rdy_pct);

            // Entries in the model: an entry stays counted until its inst
            // word has been accepted.
            entries_pre = (exp_words.size() + 1) / 2;
            hs          = out_valid && out_ready;
            if (hs) begin
                if (exp_words.size() == 0) begin
                    check("rand.spurious_beat", out_valid, 1'b0);
                end else begin
                    check("rand.data", out_data, exp_words[0]);
                    check("rand.last", out_last, (words_popped % 2 == 1));
                    void'(exp_words.pop_front());
                    words_popped++;
                end
            end
            if (trace_valid) begin
                m_ret = m_ret + 32'd1;
                m_lpc = trace_pc;
                if (entries_pre == DEPTH) begin
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end else begin
                    exp_words.push_back(trace_pc);
                    exp_words.push_back(trace_inst);
                end
            end
            pv = out_valid;
            pd = out_data;
            pl = out_last;
            step();
            if (pv && !hs) begin
                check("rand.stable_valid", out_valid, 1'b1);
                check("rand.stable_data", out_data, pd);
                check("rand.stable_last", out_last, pl);
            end
            check("rand.count", count, (exp_words.size() + 1) / 2);
            check("rand.retired", retired, m_ret);
            check("rand.dropped", dropped, m_drop);
            check("rand.last_pc", last_pc, m_lpc);
            if (exp_words.size() > 0 && !out_valid) starve++;
            else starve = 0;
            if (starve > 2) begin
                check("rand.stall_cycles", starve, 2);
                starve = 0;
            end
        end
        trace_valid = 1'b0;

`ifdef TRACE_TRIGGER_EN
        // ---------------- trigger freezes capture ----------------------------
        do_reset();
        check("trig.reset", trig_hit, 1'b0);
        trig_addr = 32'h0040000C;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) commit(32'h00400000 + 32'(4 * i), 32'hF0000000 + 32'(i));
        check("trig.count", count, 4);
        check("trig.hit", trig_hit, 1'b1);
        check("trig.retired", retired, 5);
        check("trig.dropped", dropped, 0);
        check("trig.last_pc", last_pc, 32'h00400010);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
